bus_region_router: RTL and testbench

- Parametrised successor of the two-way memory/IO address splitter.
- Routes one CPU-side data-bus master to NUM_PORTS slave ports. Each port owns an address window given by a base and a size.
- Requests are registered. Slave responses are waited on under a timeout counter, and the master gets an error response for unmapped addresses or hung slaves.
- Sits between the CPU data-memory stage and the memory controller and IO controllers.

---
 rtl/bus_region_router.sv | 191 +++++++++++++++++++
 tb/tb_bus_region_router.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_region_router.sv
// Routes one data-bus master to NUM_PORTS address windows. Requests are registered,
// slave completion is awaited under a timeout, and errors are answered locally.
module bus_region_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASES =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] SIZES = {4{32'h0000_1000}},
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            read,
  input  logic                            write,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ready,
  output logic                            err,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]            p_read,
  output logic [NUM_PORTS-1:0]            p_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_rdata,
  input  logic [NUM_PORTS-1:0]            p_ready
);

  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                          state_q;
  logic [SW-1:0]                   sel_q;
  logic                            is_wr_q;
  logic [CW-1:0]                   cnt_q;
  logic                            ready_q;
  logic                            err_q;
  logic [DATA_WIDTH-1:0]           rdata_q;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata_q;
  logic [NUM_PORTS-1:0]            p_read_q;
  logic [NUM_PORTS-1:0]            p_write_q;

  logic [NUM_PORTS-1:0]            hit_vec_s;
  logic                            hit_s;
  logic [SW-1:0]                   sel_s;
  logic [ADDR_WIDTH-1:0]           off_s;
  logic [NUM_PORTS-1:0]            onehot_s;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_spread_s;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_spread_s;
  logic                            sel_ready_s;
  logic [DATA_WIDTH-1:0]           sel_rdata_s;

  // Window compare in ADDR_WIDTH+1 bits so a window ending at the top of memory cannot wrap
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_vec_s[i] = ({1'b0, addr} >= {1'b0, BASES[i*ADDR_WIDTH +: ADDR_WIDTH]}) &&
                     ({1'b0, addr} <  ({1'b0, BASES[i*ADDR_WIDTH +: ADDR_WIDTH]} +
                                       {1'b0, SIZES[i*ADDR_WIDTH +: ADDR_WIDTH]}));
    end
  end

  // Priority select: scanning downwards lets the lowest hitting index win
  always_comb begin
    hit_s = |hit_vec_s;
    sel_s = '0;
    off_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      sel_s = hit_vec_s[i] ? SW'(i) : sel_s;
      off_s = hit_vec_s[i] ? (addr - BASES[i*ADDR_WIDTH +: ADDR_WIDTH]) : off_s;
    end
  end

  // Place the translated address and write data on the selected port only
  always_comb begin
    onehot_s       = '0;
    addr_spread_s  = '0;
    wdata_spread_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      onehot_s[i]                            = (sel_s == SW'(i));
      addr_spread_s[i*ADDR_WIDTH +: ADDR_WIDTH] = onehot_s[i] ? off_s : '0;
      wdata_spread_s[i*DATA_WIDTH +: DATA_WIDTH] = onehot_s[i] ? wdata : '0;
    end
  end

  // Response mux from the latched port; other ports' p_ready is ignored
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_ready_s = (sel_q == SW'(i)) ? p_ready[i] : sel_ready_s;
      sel_rdata_s = (sel_q == SW'(i)) ? p_rdata[i*DATA_WIDTH +: DATA_WIDTH] : sel_rdata_s;
    end
  end

  // Transaction FSM with all master- and slave-facing outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
      p_read_q  <= '0;
      p_write_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          cnt_q   <= '0;
          if ((read ^ write) && hit_s) begin
            state_q   <= S_ACCESS;
            sel_q     <= sel_s;
            is_wr_q   <= write;
            p_addr_q  <= addr_spread_s;
            p_wdata_q <= wdata_spread_s;
            p_read_q  <= read  ? onehot_s : '0;
            p_write_q <= write ? onehot_s : '0;
          end else if (read || write) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (sel_ready_s) begin
            state_q   <= S_DONE;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            rdata_q   <= is_wr_q ? '0 : sel_rdata_s;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            p_read_q  <= '0;
            p_write_q <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q   <= S_DONE;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            p_read_q  <= '0;
            p_write_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          ready_q   <= 1'b0;
          err_q     <= 1'b0;
          rdata_q   <= '0;
          p_addr_q  <= '0;
          p_wdata_q <= '0;
          p_read_q  <= '0;
          p_write_q <= '0;
        end
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign p_addr  = p_addr_q;
  assign p_wdata = p_wdata_q;
  assign p_read  = p_read_q;
  assign p_write = p_write_q;

endmodule

// File: tb/tb_bus_region_router.sv
// Randomized bench for bus_region_router: a transaction-level reference model predicts
// strobes, translated addresses and the completion pulse of every request.
module tb_bus_region_router;

  localparam int TIMEOUT = 16;
  localparam logic [127:0] BASES_A = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [127:0] SIZES_A = {4{32'h0000_1000}};
  localparam logic [127:0] BASES_B = {32'hFFFF_F000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [127:0] SIZES_B = {32'h0000_1000, 32'h0000_0000, 32'h0000_1000, 32'h0000_2000};

  int unsigned base_m [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  int unsigned size_m [4] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  rdata, u2_rdata;
  logic         ready, err, u2_ready, u2_err;
  logic [127:0] p_addr, p_wdata, u2_p_addr, u2_p_wdata;
  logic [3:0]   p_read, p_write, u2_p_read, u2_p_write;
  logic [127:0] p_rdata = '0;
  logic [127:0] p_rdata2 = '0;
  logic [3:0]   p_ready = '0;
  logic [3:0]   p_ready2 = '0;

  int n_checks = 0;
  int n_fail = 0;
  bit at_done = 1'b0;

  bus_region_router #(.BASES(BASES_A), .SIZES(SIZES_A), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .rdata(rdata), .ready(ready), .err(err), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_read(p_read), .p_write(p_write), .p_rdata(p_rdata), .p_ready(p_ready));

  bus_region_router #(.BASES(BASES_B), .SIZES(SIZES_B), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .rdata(u2_rdata), .ready(u2_ready), .err(u2_err), .p_addr(u2_p_addr), .p_wdata(u2_p_wdata),
    .p_read(u2_p_read), .p_write(u2_p_write), .p_rdata(p_rdata2), .p_ready(p_ready2));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Lowest-index window containing a, or -1 when nothing maps it
  function automatic int decode(input logic [31:0] a);
    longint unsigned la, lb, ls;
    la = a;
    for (int i = 0; i < 4; i++) begin
      lb = base_m[i];
      ls = size_m[i];
      if (la >= lb && la < lb + ls) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0; p_ready = '0; p_ready2 = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_ready_err", {ready, err}, '0);
    check("rst_rdata", rdata, '0);
    check("rst_strobes", {p_read, p_write}, '0);
    check("rst_paddr", p_addr, '0);
    check("rst_pwdata", p_wdata, '0);
    reset = 1'b0;
    at_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    read = 1'b0; write = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      check("idle_ready", {ready, err}, '0);
      check("idle_strobes", {p_read, p_write}, '0);
    end
    at_done = 1'b0;
  endtask

  // One master request on the main router; lat = strobe cycle in which the slave answers
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] dat, input int rst_at);
    int sel, n;
    bit acked;
    logic [127:0] e_addr, e_wdata;
    logic [3:0] e_strb;
    read = rd; write = wr; addr = a; wdata = wd;
    if (at_done) begin
      @(posedge clk); @(negedge clk);
      check("gap_ready", {ready, err}, '0);
      check("gap_strobes", {p_read, p_write}, '0);
    end
    @(posedge clk);
    sel = decode(a);
    at_done = 1'b1;
    if ((rd && wr) || sel < 0) begin
      @(negedge clk);
      check("err_ready_err", {ready, err}, 2'b11);
      check("err_rdata", rdata, '0);
      check("err_strobes", {p_read, p_write}, '0);
      return;
    end
    acked = (lat >= 1 && lat <= TIMEOUT);
    n = acked ? lat : TIMEOUT;
    e_addr = '0; e_wdata = '0;
    e_addr[sel*32 +: 32] = a - base_m[sel];
    e_wdata[sel*32 +: 32] = wd;
    e_strb = 4'b0001 << sel;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("strobe_rd", p_read, rd ? e_strb : 4'b0000);
      check("strobe_wr", p_write, wr ? e_strb : 4'b0000);
      check("p_addr", p_addr, e_addr);
      check("p_wdata", p_wdata, e_wdata);
      check("busy_ready", ready, '0);
      addr = $urandom; wdata = $urandom;
      p_ready = 4'($urandom);
      p_ready[sel] = (k == lat);
      p_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (k == lat) p_rdata[sel*32 +: 32] = dat;
      if (k == rst_at) begin
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; read = 1'b0; write = 1'b0; p_ready = '0;
        check("midrst_strobes", {p_read, p_write}, '0);
        check("midrst_ready", {ready, err}, '0);
        check("midrst_paddr", p_addr, '0);
        @(posedge clk); @(negedge clk);
        check("midrst_no_pulse", {ready, err}, '0);
        at_done = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    p_ready = '0;
    check("done_ready", ready, 1'b1);
    check("done_err", err, !acked);
    check("done_rdata", rdata, (acked && rd) ? dat : 32'h0000_0000);
    check("done_strobes", {p_read, p_write}, '0);
    check("done_paddr", p_addr, '0);
  endtask

  // Directed read on the second router (overlap, top-of-space and disabled windows)
  task automatic d2_read(input logic [31:0] a, input logic [3:0] e_strb, input logic [31:0] e_off);
    logic [127:0] e_addr;
    logic [31:0] dat;
    int idx;
    read = 1'b1; write = 1'b0; addr = a; wdata = 32'h0000_0000;
    dat = a ^ 32'h5A5A_0000;
    @(posedge clk); @(negedge clk);
    if (e_strb == 4'b0000) begin
      check("d2_unmapped", {u2_ready, u2_err}, 2'b11);
      check("d2_unmapped_strb", {u2_p_read, u2_p_write}, '0);
    end else begin
      e_addr = '0; idx = 0;
      for (int i = 0; i < 4; i++) if (e_strb[i]) idx = i;
      e_addr[idx*32 +: 32] = e_off;
      check("d2_strobe", {u2_p_read, u2_p_write}, {e_strb, 4'b0000});
      check("d2_paddr", u2_p_addr, e_addr);
      check("d2_pwdata", u2_p_wdata, '0);
      p_rdata2 = {$urandom, $urandom, $urandom, $urandom};
      p_rdata2[idx*32 +: 32] = dat;
      p_ready2 = e_strb;
      @(posedge clk); @(negedge clk);
      p_ready2 = '0;
      check("d2_done", {u2_ready, u2_err}, 2'b10);
      check("d2_rdata", u2_rdata, dat);
    end
    read = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int kind, lat, gap;
    bit rd, wr;
    logic [31:0] a;

    do_reset();
    d2_read(32'h0000_1004, 4'b0001, 32'h0000_1004);
    d2_read(32'hFFFF_FFFC, 4'b1000, 32'h0000_0FFC);
    d2_read(32'h0000_2004, 4'b0000, 32'h0000_0000);
    d2_read(32'h0000_1FFC, 4'b0001, 32'h0000_1FFC);

    do_reset();
    run_txn(1'b1, 1'b0, 32'h0000_1010, 32'h0000_0000, 1, 32'hCAFE_BABE, 0);
    run_txn(1'b0, 1'b1, 32'h0000_3FFC, 32'h1234_5678, 5, 32'h0000_0000, 0);
    idle_cycles(1);
    run_txn(1'b1, 1'b0, 32'h0000_8000, 32'h0000_0000, 1, 32'h0000_0000, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 32'h0000_0000, 0);
    run_txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_0000, 1, 32'h0000_0000, 0);
    idle_cycles(2);
    run_txn(1'b1, 1'b0, 32'h0000_2008, 32'h0000_0000, 0, 32'h0000_0000, 3);
    run_txn(1'b1, 1'b0, 32'h0000_2008, 32'h0000_0000, 2, 32'h0BAD_F00D, 0);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 0) || (kind >= 1 && kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'h0000_3FF8 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 32'h3FFF));
      endcase
      lat = $urandom_range(0, TIMEOUT + 2);
      run_txn(rd, wr, a, $urandom, lat, $urandom, 0);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle_cycles(gap);
    end
    idle_cycles(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
